// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the rv32i core. It fetches an instruction into
//   the IR and holds it stable for the decoder/ALU. It then steps the
//   instruction through DECODE, EXEC, optional MEM and WB. Register/CSR write
//   strobes and the PC update happen only in the single WB cycle. The core
//   halts permanently (until reset) on an illegal instruction or on a bus
//   timeout.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   MEM_TIMEOUT  max ready-wait cycles on imem/dmem before bus error (>=1)
//
// Ports
//   clk_i           core clock
//   rst_ni          asynchronous active-low reset
//   imem_req_o      instruction fetch request
//   imem_addr_o     fetch address (always the architectural PC)
//   imem_ready_i    fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i    fetched instruction
//   instr_o         latched IR, drives the decoder
//   dec_illegal_i   decoder: unsupported opcode/funct3
//   dec_mem_i       decoder: load or store
//   dec_store_i     decoder: memory op is a store
//   dec_r_we_i      decoder: register write request
//   dec_csr_we_i    decoder: CSR write request
//   next_pc_i       datapath-computed next PC
//   pc_o            architectural PC
//   dmem_req_o      data access request
//   dmem_we_o       data access is a write (valid with dmem_req_o)
//   dmem_ready_i    data access complete
//   reg_we_o        register file write strobe
//   csr_we_o        CSR write strobe
//   retire_o        one-cycle pulse per completed instruction
//   instret_o       retired instruction count
//   halted_o        core stopped (sticky until reset)
//   bus_err_o       halt cause was a bus timeout (sticky until reset)
// ---------------------------------------------------------------------------
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  input  logic        dec_illegal_i,
  input  logic        dec_mem_i,
  input  logic        dec_store_i,
  input  logic        dec_r_we_i,
  input  logic        dec_csr_we_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ready_i,
  output logic        reg_we_o,
  output logic        csr_we_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        halted_o,
  output logic        bus_err_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      instret_q, instret_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             bus_err_q, bus_err_d;

  // State and datapath-control registers. Reset is asynchronous so every
  // request and strobe (all decoded from state_q) drops the moment rst_ni falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NopInstr;
      instret_q <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and output decode. Ready inputs are only looked at in the
  // state that owns the matching request, so a stray ready is ignored.
  // The wait counter is cleared whenever FETCH or MEM is entered.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    reg_we_o   = 1'b0;
    csr_we_o   = 1'b0;
    retire_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = S_DECODE;
        end else if (wait_q == WaitMax) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      S_DECODE: begin
        state_d = dec_illegal_i ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem_i) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_store_i;
        if (dmem_ready_i) begin
          state_d = S_WB;
        end else if (wait_q == WaitMax) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      S_WB: begin
        reg_we_o  = dec_r_we_i;
        csr_we_o  = dec_csr_we_i;
        retire_o  = 1'b1;
        pc_d      = next_pc_i;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign instret_o   = instret_q;
  assign halted_o    = (state_q == S_HALT);
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
//   Self-checking bench for core_sequencer. Expected per-instruction results
//   are queued when an instruction is presented on the fetch bus and popped
//   when the sequencer retires it. The decoder is modelled by driving the
//   dec_* inputs directly for each instruction.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        dec_illegal, dec_mem, dec_store, dec_r_we, dec_csr_we;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        reg_we, csr_we, retire;
  logic [31:0] instret;
  logic        halted, bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instret;

  typedef struct {
    logic [31:0] instr;
    logic        rwe;
    logic        cwe;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  core_sequencer #(
    .RESET_PC   (RESET_PC),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .dec_illegal_i(dec_illegal),
    .dec_mem_i    (dec_mem),
    .dec_store_i  (dec_store),
    .dec_r_we_i   (dec_r_we),
    .dec_csr_we_i (dec_csr_we),
    .next_pc_i    (next_pc),
    .pc_o         (pc),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_ready_i (dmem_ready),
    .reg_we_o     (reg_we),
    .csr_we_o     (csr_we),
    .retire_o     (retire),
    .instret_o    (instret),
    .halted_o     (halted),
    .bus_err_o    (bus_err)
  );

  // Hard stop in case a task loop is ever broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset sequence with reset-state checks, ending at the first FETCH cycle.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    dec_illegal = 1'b0; dec_mem = 1'b0; dec_store = 1'b0;
    dec_r_we = 1'b0; dec_csr_we = 1'b0; next_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, dmem_req, dmem_we, reg_we, csr_we, retire, halted, bus_err} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {imem_req, dmem_req, dmem_we, reg_we, csr_we, retire, halted, bus_err});
    end
    checks++;
    if (pc !== RESET_PC || instr !== 32'h0000_0013 || instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs: pc=%h instr=%h instret=%0d expected %h 00000013 0",
               pc, instr, instret, RESET_PC);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: imem_req=%b expected 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL first_fetch: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    model_pc = RESET_PC;
    model_instret = 32'd0;
    sb.delete();
  endtask

  // Runs one legal instruction from the current FETCH cycle through WB.
  task automatic run_instr(input logic [31:0] ir, input logic is_mem, input logic is_store,
                           input logic rwe, input logic cwe, input logic [31:0] npc,
                           input int iwait, input int dwait, input bit stray);
    exp_t e;
    exp_t got;
    int   lat = 0;
    int   fw = 0;
    int   dw = 0;
    bit   done = 1'b0;
    e.instr = ir; e.rwe = rwe; e.cwe = cwe;
    e.lat = 4 + iwait + (is_mem ? dwait + 1 : 0);
    sb.push_back(e);
    imem_rdata = ir; dec_illegal = 1'b0; dec_mem = is_mem; dec_store = is_store;
    dec_r_we = rwe; dec_csr_we = cwe; next_pc = npc;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
      errors++;
      $display("[TB] FAIL fetch_addr: req=%b addr=%h expected 1 %h", imem_req, imem_addr, model_pc);
    end
    while (!done && lat < 40) begin
      lat++;
      imem_ready = imem_req ? (fw == iwait) : stray;
      if (imem_req) fw++;
      dmem_ready = dmem_req ? (dw == dwait) : stray;
      if (dmem_req) begin
        dw++;
        checks++;
        if (dmem_we !== is_store) begin
          errors++;
          $display("[TB] FAIL dmem_we: got %b expected %b", dmem_we, is_store);
        end
      end
      checks++;
      if (!retire && (reg_we !== 1'b0 || csr_we !== 1'b0)) begin
        errors++;
        $display("[TB] FAIL strobe_outside_wb: reg_we=%b csr_we=%b expected 0 0", reg_we, csr_we);
      end
      if (retire === 1'b1) begin
        done = 1'b1;
        got = sb.pop_front();
        checks++;
        if (lat !== got.lat) begin
          errors++;
          $display("[TB] FAIL retire_latency: got %0d expected %0d", lat, got.lat);
        end
        checks++;
        if (reg_we !== got.rwe || csr_we !== got.cwe) begin
          errors++;
          $display("[TB] FAIL wb_strobes: reg_we=%b csr_we=%b expected %b %b",
                   reg_we, csr_we, got.rwe, got.cwe);
        end
        checks++;
        if (instr !== got.instr) begin
          errors++;
          $display("[TB] FAIL ir_hold: got %h expected %h", instr, got.instr);
        end
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL retire_timeout: no retire in %0d cycles expected %0d", lat, e.lat);
    end
    if (is_mem) begin
      checks++;
      if (dw !== dwait + 1) begin
        errors++;
        $display("[TB] FAIL dmem_req_cycles: got %0d expected %0d", dw, dwait + 1);
      end
    end
    model_pc = npc;
    model_instret = model_instret + 32'd1;
    checks++;
    if (pc !== model_pc || instret !== model_instret) begin
      errors++;
      $display("[TB] FAIL pc_instret: pc=%h instret=%0d expected %h %0d",
               pc, instret, model_pc, model_instret);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
      errors++;
      $display("[TB] FAIL refetch: req=%b addr=%h expected 1 %h", imem_req, imem_addr, model_pc);
    end
  endtask

  task automatic test_addi();
    run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, model_pc + 32'd4, 0, 0, 1'b0);
  endtask

  task automatic test_store();
    run_instr(32'h0020_a023, 1'b1, 1'b1, 1'b0, 1'b0, model_pc + 32'd4, 0, 3, 1'b0);
  endtask

  task automatic test_load_stray();
    run_instr(32'h0000_a103, 1'b1, 1'b0, 1'b1, 1'b0, model_pc + 32'd4, 2, 0, 1'b1);
  endtask

  task automatic test_jal();
    run_instr(32'h1000_00ef, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 0, 1'b0);
  endtask

  task automatic test_csr();
    run_instr(32'h3400_9073, 1'b0, 1'b0, 1'b1, 1'b1, model_pc + 32'd4, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      run_instr(32'h0010_8093 + i, i[0], i[1], ~i[1], 1'b0, model_pc + 32'd4,
                $urandom_range(0, 2), $urandom_range(0, 2), 1'(i % 3 == 0));
    end
  endtask

  // Asynchronous reset in the middle of a MEM wait must kill the access.
  task automatic test_reset_mid_mem();
    int n = 0;
    imem_rdata = 32'h0000_a183; dec_illegal = 1'b0; dec_mem = 1'b1; dec_store = 1'b1;
    dec_r_we = 1'b1; dec_csr_we = 1'b1; next_pc = model_pc + 32'd4;
    dmem_ready = 1'b0;
    while (dmem_req !== 1'b1 && n < 10) begin
      imem_ready = imem_req;
      n++;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reach_mem: dmem_req=%b expected 1", dmem_req);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || reg_we !== 1'b0 || csr_we !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_abort: req=%b we=%b reg_we=%b csr_we=%b retire=%b expected all 0",
               dmem_req, dmem_we, reg_we, csr_we, retire);
    end
    checks++;
    if (pc !== RESET_PC || instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_regs: pc=%h instret=%0d expected %h 0", pc, instret, RESET_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL restart_fetch: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    model_pc = RESET_PC;
    model_instret = 32'd0;
    run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    test_reset();
    imem_rdata = 32'hFFFF_FFFF; dec_illegal = 1'b1; dec_mem = 1'b1; dec_store = 1'b1;
    dec_r_we = 1'b1; dec_csr_we = 1'b1; next_pc = 32'h0000_0040;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (reg_we !== 1'b0 || csr_we !== 1'b0 || retire !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_strobes: cyc=%0d reg_we=%b csr_we=%b retire=%b dmem_req=%b expected 0",
                 c, reg_we, csr_we, retire, dmem_req);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (halted !== (c == 2)) begin
          errors++;
          $display("[TB] FAIL illegal_halt_time: cyc=%0d halted=%b expected %b", c, halted, (c == 2));
        end
      end
      @(negedge clk);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_state: halted=%b bus_err=%b imem_req=%b expected 1 0 0",
               halted, bus_err, imem_req);
    end
    checks++;
    if (pc !== RESET_PC || instr !== 32'hFFFF_FFFF || instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL illegal_frozen: pc=%h instr=%h instret=%0d expected %h ffffffff 0",
               pc, instr, instret, RESET_PC);
    end
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int n = 0;
    test_reset();
    dec_illegal = 1'b0;
    imem_ready = 1'b0;
    while (halted !== 1'b1 && n < 20) begin
      if (imem_req === 1'b1) reqs++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (reqs !== 5) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d fetch cycles expected 5", reqs);
    end
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: halted=%b bus_err=%b imem_req=%b expected 1 1 0",
               halted, bus_err, imem_req);
    end
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b1 || imem_req !== 1'b0 || pc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL halt_sticky: halted=%b bus_err=%b imem_req=%b pc=%h expected 1 1 0 %h",
               halted, bus_err, imem_req, pc, RESET_PC);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    dec_illegal = 1'b0; dec_mem = 1'b0; dec_store = 1'b0;
    dec_r_we = 1'b0; dec_csr_we = 1'b0; next_pc = '0;
    model_pc = RESET_PC;
    model_instret = 32'd0;
    test_reset();
    test_addi();
    test_store();
    test_load_stray();
    test_jal();
    test_csr();
    test_back_to_back();
    test_reset_mid_mem();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
